alu_muldiv_seq: RTL and testbench



---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_addsub.sv | 18 +
 rtl/alu_muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Signed operation is built only when MULDIV_SIGNED_EN is defined.
package muldiv_pkg;

  localparam int MULDIV_N = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/muldiv_addsub.sv
// N-bit adder/subtractor with carry-out; a subtract yields carry-out 1
// when there is no borrow.
module muldiv_addsub #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N-1:0] b_x;

  assign b_x = sub_i ? ~b_i : b_i;
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_x} + {{N{1'b0}}, sub_i};

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative shift/add multiplier and restoring divider, one bit per cycle.
// Define MULDIV_SIGNED_EN to honour signed_i (abs at load, fixup at DONE).
module alu_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int N     = MULDIV_N,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         op_i,
  input  logic         signed_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o,
  output logic         divzero_o,
  output logic         zeroflag_o
);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] lo_q, lo_d;
  logic [N-1:0] opnd_q, opnd_d;
  logic op_q, op_d;
  logic dz_q, dz_d;
  logic zf_q, zf_d;

  logic [N-1:0] a_abs, b_abs;
  logic [N-1:0] as_a, as_b, as_s;
  logic as_sub, as_co;
  logic [N-1:0] sh_hi, step_hi, step_lo;
  logic take;

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_d;
  logic rneg_q, rneg_d;
  logic a_neg, b_neg;
  logic [2*N-1:0] prod_n;

  always_comb begin
    a_neg = signed_i & a_i[N-1];
    b_neg = signed_i & b_i[N-1];
    a_abs = a_neg ? -a_i : a_i;
    b_abs = b_neg ? -b_i : b_i;
  end
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign a_abs = a_i;
  assign b_abs = b_i;
`endif

  // Divide works on the pre-shifted remainder; multiply adds into hi.
  assign sh_hi = {hi_q[N-2:0], lo_q[N-1]};

  always_comb begin
    as_sub = (op_q == OP_DIV);
    as_a = as_sub ? sh_hi : hi_q;
    as_b = (as_sub || lo_q[0]) ? opnd_q : '0;
  end

  muldiv_addsub #(.N(N)) u_addsub (
    .a_i   (as_a),
    .b_i   (as_b),
    .sub_i (as_sub),
    .sum_o (as_s),
    .cout_o(as_co)
  );

  // Bit shifted out of hi stands in for the N+1th remainder bit.
  always_comb begin
    take = hi_q[N-1] | as_co;
    if (op_q == OP_DIV) begin
      step_hi = take ? as_s : sh_hi;
      step_lo = {lo_q[N-2:0], take};
    end else begin
      step_hi = {as_co, as_s[N-1:1]};
      step_lo = {as_s[0], lo_q[N-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    dz_d    = dz_q;
`ifdef MULDIV_SIGNED_EN
    neg_d  = neg_q;
    rneg_d = rneg_q;
    prod_n = -{step_hi, step_lo};
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          op_d = op_i;
          dz_d = (op_i == OP_DIV) && (b_i == '0);
          hi_d = '0;
`ifdef MULDIV_SIGNED_EN
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
`endif
          if ((op_i == OP_DIV) && (b_i == '0)) begin
            state_d = S_DONE;
            cnt_d   = '0;
            hi_d    = a_i;
            lo_d    = '1;
          end else begin
            state_d = S_RUN;
            cnt_d   = CNT_W'(N);
            lo_d    = (op_i == OP_DIV) ? a_abs : b_abs;
            opnd_d  = (op_i == OP_DIV) ? b_abs : a_abs;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
`ifdef MULDIV_SIGNED_EN
          if (op_q == OP_MUL) begin
            if (neg_q) {hi_d, lo_d} = prod_n;
          end else begin
            if (neg_q) lo_d = -step_lo;
            if (rneg_q) hi_d = -step_hi;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    zf_d = (lo_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= OP_MUL;
      dz_q    <= 1'b0;
      zf_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
      zf_q    <= zf_d;
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
    end
  end
`endif

  assign busy_o     = (state_q == S_RUN);
  assign done_o     = (state_q == S_DONE);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign divzero_o  = dz_q;
  assign zeroflag_o = zf_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Random and directed checks of alu_muldiv_seq against a plain-arithmetic
// model; signed cases are modelled only when MULDIV_SIGNED_EN is defined.
module tb_alu_muldiv_seq;

  logic clk = 1'b0;
  logic rst_i, start_i, op_i, signed_i;
  logic [31:0] a_i, b_i, hi_o, lo_o;
  logic busy_o, done_o, divzero_o, zeroflag_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.N(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .signed_i  (signed_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .divzero_o (divzero_o),
    .zeroflag_o(zeroflag_o)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic op, input logic sg,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh,
                                output logic [31:0] el,
                                output logic edz);
    logic [63:0] p;
    longint sa, sb, q, r;
    logic s;
`ifdef MULDIV_SIGNED_EN
    s = sg;
`else
    s = sg & 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edz = op && (b == 0);
    if (!op) begin
      if (s) begin
        q = sa * sb;
        p = q;
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 0) begin
      eh = a;
      el = '1;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction

  task automatic run_op(input logic op, input logic sg,
                        input logic [31:0] a, input logic [31:0] b,
                        input int inj);
    logic [31:0] eh, el;
    logic edz;
    int cyc, lat;
    model(op, sg, a, b, eh, el, edz);
    lat = (op && b == 0) ? 1 : 33;
    op_i = op; signed_i = sg; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    if (lat > 1) check("busy_run", busy_o, 1);
    while (!done_o && cyc < 64) begin
      if (cyc == inj) begin
        start_i = 1'b1; a_i = ~a; b_i = b + 3;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    check("latency", cyc, lat);
    check("hi", hi_o, eh);
    check("lo", lo_o, el);
    check("divzero", divzero_o, edz);
    check("zeroflag", zeroflag_o, el == 0);
    check("busy_done", busy_o, 0);
    @(posedge clk); #1;
    check("done_pulse", done_o, 0);
    check("lo_hold", lo_o, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: pick = $urandom_range(0, 20);
      1: pick = 32'hFFFF_FFFF - $urandom_range(0, 20);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    int cyc, seen;
    logic [31:0] ra, rb;
    rst_i = 1'b1; start_i = 1'b0; op_i = 1'b0; signed_i = 1'b0;
    a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_dz", divzero_o, 0);
    check("rst_zf", zeroflag_o, 1);

    run_op(1'b0, 1'b0, 32'd7, 32'd6, 0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 0);
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 0);
    run_op(1'b0, 1'b0, 32'd0, 32'd9, 0);
    run_op(1'b0, 1'b0, 32'h1234_5678, 32'd1000, 10);

    // reset in the middle of an operation
    op_i = 1'b0; a_i = 32'd11; b_i = 32'd13; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("mrst_busy", busy_o, 0);
    check("mrst_done", done_o, 0);
    check("mrst_hi", hi_o, 0);
    check("mrst_lo", lo_o, 0);
    check("mrst_zf", zeroflag_o, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) seen++;
    end
    check("mrst_nodone", seen, 0);

    // back-to-back with start held through DONE
    op_i = 1'b0; a_i = 32'd3; b_i = 32'd5; start_i = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (!done_o && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_lat1", cyc, 33);
    check("b2b_lo1", lo_o, 15);
    a_i = 32'd9; b_i = 32'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_lat2", cyc, 33);
    check("b2b_lo2", lo_o, 81);
    @(posedge clk); #1;

`ifdef MULDIV_SIGNED_EN
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
